// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC/nPC pair with delayed-branch nPC selection and IF/ID register.
// Optional IF_ALIGN_CHECK_EN: clear target bits [1:0] on misaligned loads and pulse misalign.
module if_fetch_unit #(
    parameter int unsigned    W        = 32,
    parameter logic [W-1:0]   RESET_PC = '0,
    parameter logic [W-1:0]   TRAP_VEC = W'(32'h0000_0080)
) (
    input  logic             clk,
    input  logic             R,
    input  logic             le,
    input  logic             flush,
    input  logic [1:0]       sel,
    input  logic [W-1:0]     ta,
    input  logic [W-1:0]     alu_out,
    output logic [W-1:0]     imem_addr,
    input  logic [31:0]      imem_data,
    output logic [W-1:0]     pc,
    output logic [W-1:0]     npc,
    output logic [31:0]      ifid_instr,
    output logic [W-1:0]     ifid_pc,
    output logic             ifid_valid,
    output logic             misalign
);

    logic [W-1:0] r_pc;
    logic [W-1:0] r_npc;
    logic [31:0]  r_ifid_instr;
    logic [W-1:0] r_ifid_pc;
    logic         r_ifid_valid;
    logic [W-1:0] w_target;
    logic [W-1:0] w_npc_next;

    always_comb begin
        w_target = r_npc + W'(4);
        unique case (sel)
            2'b00:   w_target = r_npc + W'(4);
            2'b01:   w_target = ta;
            2'b10:   w_target = alu_out;
            2'b11:   w_target = TRAP_VEC;
            default: w_target = r_npc + W'(4);
        endcase
    end

`ifdef IF_ALIGN_CHECK_EN
    logic w_misaligned;
    logic r_misalign;

    // Sequential increments stay aligned; only redirected targets are checked.
    always_comb begin
        w_misaligned = (sel != 2'b00) && (w_target[1:0] != 2'b00);
        w_npc_next   = w_misaligned ? {w_target[W-1:2], 2'b00} : w_target;
    end

    always_ff @(posedge clk) begin
        if (R) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= le & w_misaligned;
        end
    end

    assign misalign = r_misalign;
`else
    always_comb begin
        w_npc_next = w_target;
    end

    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (R) begin
            r_pc         <= RESET_PC;
            r_npc        <= RESET_PC + W'(4);
            r_ifid_instr <= '0;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
        end else begin
            if (le) begin
                r_pc  <= r_npc;
                r_npc <= w_npc_next;
            end
            // Flush annuls IF/ID independently of le; PC/nPC still follow le.
            if (flush) begin
                r_ifid_instr <= '0;
                r_ifid_pc    <= '0;
                r_ifid_valid <= 1'b0;
            end else if (le) begin
                r_ifid_instr <= imem_data;
                r_ifid_pc    <= r_pc;
                r_ifid_valid <= 1'b1;
            end
        end
    end

    assign pc         = r_pc;
    assign npc        = r_npc;
    assign imem_addr  = r_pc;
    assign ifid_instr = r_ifid_instr;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand-written corner sequences,
// then randomized stimulus against a behavioural PC/nPC model.
module tb_if_fetch_unit;

    logic        clk;
    logic        R;
    logic        le;
    logic        flush;
    logic [1:0]  sel;
    logic [31:0] ta;
    logic [31:0] alu_out;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic        misalign;

    int checks;
    int failures;

    // Reference model state
    logic [31:0] m_pc, m_npc, m_instr, m_ipc;
    logic        m_valid, m_mis;

    if_fetch_unit #(
        .W        (32),
        .RESET_PC (32'h0),
        .TRAP_VEC (32'h0000_0080)
    ) dut (
        .clk        (clk),
        .R          (R),
        .le         (le),
        .flush      (flush),
        .sel        (sel),
        .ta         (ta),
        .alu_out    (alu_out),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .pc         (pc),
        .npc        (npc),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .ifid_valid (ifid_valid),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic l, input logic f, input logic [1:0] s,
                              input logic [31:0] t, input logic [31:0] a);
        logic [31:0] tgt;
        logic        mis;
        if (r) begin
            m_pc = 0; m_npc = 4; m_instr = 0; m_ipc = 0; m_valid = 0; m_mis = 0;
        end else begin
            case (s)
                2'd0:    tgt = m_npc + 32'd4;
                2'd1:    tgt = t;
                2'd2:    tgt = a;
                default: tgt = 32'h80;
            endcase
            mis = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            if (s != 2'd0 && (tgt % 4) != 0) begin
                mis = 1'b1;
                tgt = tgt - (tgt % 4);
            end
`endif
            if (f) begin
                m_instr = 0; m_ipc = 0; m_valid = 0;
            end else if (l) begin
                m_instr = mem_word(m_pc); m_ipc = m_pc; m_valid = 1;
            end
            m_mis = l && mis;
            if (l) begin
                m_pc  = m_npc;
                m_npc = tgt;
            end
        end
    endtask

    // Drive inputs, clock once, advance the model, sample 1 ns after the edge.
    task automatic apply(input logic r, input logic l, input logic f, input logic [1:0] s,
                         input logic [31:0] t, input logic [31:0] a);
        R = r; le = l; flush = f; sel = s; ta = t; alu_out = a;
        @(posedge clk);
        model_step(r, l, f, s, t, a);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc"},       pc,                  m_pc);
        check({tag, ".npc"},      npc,                 m_npc);
        check({tag, ".imem"},     imem_addr,           m_pc);
        check({tag, ".instr"},    ifid_instr,          m_instr);
        check({tag, ".ifid_pc"},  ifid_pc,             m_ipc);
        check({tag, ".valid"},    {31'd0, ifid_valid}, {31'd0, m_valid});
        check({tag, ".misalign"}, {31'd0, misalign},   {31'd0, m_mis});
    endtask

    typedef struct {
        logic        r, l, f;
        logic [1:0]  s;
        logic [31:0] t, a;
        logic [31:0] e_pc, e_npc, e_ipc;
        logic        e_v;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [31:0] e_instr;
        checks = 0; failures = 0;
        R = 1; le = 0; flush = 0; sel = 0; ta = 0; alu_out = 0;

        //         r     l     f     sel   ta          alu           pc            npc           ifid_pc       v
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0,  32'h0,        32'h0,        32'h4,        32'h0,        1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0,  32'h0,        32'h4,        32'h8,        32'h0,        1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0,  32'h0,        32'h8,        32'hC,        32'h4,        1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h40, 32'h0,        32'hC,        32'h40,       32'h8,        1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0,  32'h0,        32'h40,       32'h44,       32'hC,        1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'd1, 32'h99, 32'h0,        32'h40,       32'h44,       32'hC,        1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'd2, 32'h0,  32'h77,       32'h40,       32'h44,       32'hC,        1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd3, 32'h0,  32'h0,        32'h40,       32'h44,       32'hC,        1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0,  32'h0,        32'h44,       32'h48,       32'h40,       1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  32'h0,        32'h44,       32'h48,       32'h0,        1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 2'd0, 32'h0,  32'h0,        32'h48,       32'h4C,       32'h0,        1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 2'd3, 32'h0,  32'h0,        32'h4C,       32'h80,       32'h48,       1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h0,  32'hFFFF_FFFC, 32'h80,      32'hFFFF_FFFC, 32'h4C,      1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0,  32'h0,        32'hFFFF_FFFC, 32'h0,       32'h80,       1'b1};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0,  32'h0,        32'h0,        32'h4,        32'hFFFF_FFFC, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 2'd1, 32'h40, 32'h0,        32'h0,        32'h4,        32'h0,        1'b0};

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].r, tbl[i].l, tbl[i].f, tbl[i].s, tbl[i].t, tbl[i].a);
            e_instr = tbl[i].e_v ? mem_word(tbl[i].e_ipc) : 32'h0;
            check($sformatf("vec%0d.pc", i),      pc,                  tbl[i].e_pc);
            check($sformatf("vec%0d.npc", i),     npc,                 tbl[i].e_npc);
            check($sformatf("vec%0d.ifid_pc", i), ifid_pc,             tbl[i].e_ipc);
            check($sformatf("vec%0d.valid", i),   {31'd0, ifid_valid}, {31'd0, tbl[i].e_v});
            check($sformatf("vec%0d.instr", i),   ifid_instr,          e_instr);
            check($sformatf("vec%0d.misalign", i), {31'd0, misalign},  32'd0);
        end

        // Misaligned jmpl target, then a stall cycle: misalign must be a single-cycle pulse.
        apply(1'b0, 1'b1, 1'b0, 2'd2, 32'h0, 32'h102);
        apply(1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0);
`ifdef IF_ALIGN_CHECK_EN
        check("align.npc", pc, 32'h100);
`else
        check("align.npc", pc, 32'h102);
`endif
        check_model("align");
        apply(1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h102);
        check("align.drop", {31'd0, misalign}, 32'd0);
        check_model("align_stall");

        // All-ones target followed by a sequential step exercises wrap-around.
        apply(1'b0, 1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0);
        apply(1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0);
        check_model("wrap1");
`ifdef IF_ALIGN_CHECK_EN
        check("wrap.npc", npc, 32'h0);
`else
        check("wrap.npc", npc, 32'h3);
`endif

        // Misaligned trap vector is never produced here; trap from a reset-fresh state.
        apply(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        check_model("rst2");
        apply(1'b0, 1'b1, 1'b0, 2'd3, 32'h0, 32'h0);
        check("trap.npc", npc, 32'h80);

        for (int i = 0; i < 400; i++) begin
            logic        r, l, f;
            logic [1:0]  s;
            logic [31:0] t, a;
            r = ($urandom_range(0, 49) == 0);
            l = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 6) == 0);
            s = 2'($urandom_range(0, 3));
            t = $urandom;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            apply(r, l, f, s, t, a);
            check_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Parametrised instruction-fetch stage for the SPARC pipeline. Holds the architectural PC/nPC pair, selects the next nPC among sequential, branch target, ALU (jmpl) and trap-vector sources, and drives a combinational instruction memory. Registers the fetched word into an IF/ID pipeline register with valid, stall (hold) and flush (annul) control. Sits between the branch/ALU resolution logic and the ID stage.

## Interface

Parameters:
- W, 32, address/data width of PC, nPC and targets
- RESET_PC, 0, PC value after reset (nPC resets to RESET_PC+4)
- TRAP_VEC, 32'h0000_0080, nPC value loaded when sel = 2'b11

Ports:
- clk  in  1  clock, all state updates on rising edge
- R  in  1  synchronous active-high reset
- le  in  1  load enable; 0 = stall, PC/nPC/IF-ID hold
- flush  in  1  annul the IF/ID contents (insert bubble)
- sel  in  2  nPC source: 00 nPC+4, 01 ta, 10 alu_out, 11 TRAP_VEC
- ta  in  W  branch target address
- alu_out  in  W  jmpl target from ALU
- imem_addr  out  W  byte address to instruction memory (= pc)
- imem_data  in  32  instruction word, combinational, valid same cycle as imem_addr
- pc  out  W  current PC
- npc  out  W  current nPC
- ifid_instr  out  32  registered instruction for ID
- ifid_pc  out  W  PC of ifid_instr
- ifid_valid  out  1  ifid_instr is a real instruction (0 = bubble)
- misalign  out  1  registered pulse: loaded target had addr[1:0] != 0 (see Configuration)

## Operation

- Reset (R=1, any le/flush): pc=RESET_PC, npc=RESET_PC+4, ifid_instr=0, ifid_pc=0, ifid_valid=0, misalign=0. R dominates all inputs.
- Advance (R=0, le=1): pc<=npc; npc<=source(sel); IF/ID <= {imem_data, pc, valid=1}. Delayed-branch semantics: instruction at old npc (delay slot) is always fetched next.
- nPC+4 uses W-bit wrap-around addition; no carry out, all-ones+4 wraps to 3.
- Stall (le=0, flush=0): pc, npc, IF/ID, misalign source all hold; misalign drops to 0.
- Flush (flush=1): IF/ID loads instr=0, pc=0, valid=0 regardless of le. PC/nPC still follow le (advance if le=1, hold if le=0). Flush+R: reset wins.
- imem_addr is a continuous copy of pc; no memory state in this block.

## Timing

- Fetch latency: 1 cycle from pc change to ifid_instr.
- Redirect: sel/ta sampled at edge N; new target appears on npc after N, on pc after N+1, in ifid_instr after N+2.
- No internal handshake; le is the only flow control, must be stable before the edge.
- First valid ifid_instr appears on the first le=1 edge after R deasserts (instruction at RESET_PC).
- misalign is valid the cycle after the offending load, one cycle wide per offending edge.

## Configuration

- IF_ALIGN_CHECK_EN defined: when an advance selects ta or alu_out (sel 01/10) with target[1:0] != 0, npc loads target with bits [1:0] cleared and misalign=1 next cycle. Applies to TRAP_VEC only if misaligned (same rule).
- Undefined: target loaded unmodified; misalign tied to 0; no alignment logic synthesised.

## Test plan

- Reset then 4 edges le=1, sel=00, RESET_PC=0 -> pc 0,4,8,12; ifid_pc 0,4,8 with ifid_valid=1 from 1st edge.
- Branch: at pc=8/npc=12 assert sel=01, ta=0x40 one edge -> next pc=12 (delay slot), npc=0x40; following pc=0x40, npc=0x44.
- Stall: le=0 for 3 cycles mid-stream -> pc, npc, ifid_* unchanged; resume continues sequence without skip or repeat.
- Flush with le=0 -> ifid_valid=0, ifid_instr=0, pc/npc held; flush with le=1 -> bubble and pc advances.
- sel=11 -> npc=TRAP_VEC; npc=0xFFFF_FFFC, sel=00 -> npc wraps to 0.
- With IF_ALIGN_CHECK_EN: sel=10, alu_out=0x102 -> npc=0x100, misalign=1 for one cycle; without macro -> npc=0x102, misalign=0.
